// File: rtl/opm_pg_acc_if.sv
// Slot-multiplexed phase-accumulator bus: per-slot inputs from the sequencer and
// delay line, new phase back to the delay line plus registered operator sample.
interface opm_pg_acc_if #(
  parameter int PHASE_W = 20,
  parameter int PINC_W  = 17,
  parameter int OUT_W   = 10,
  parameter int SLOTS   = 32
);
  localparam int SLOT_W = $clog2(SLOTS);

  logic                cen;
  logic [PINC_W-1:0]   pinc;
  logic                keyon;
  logic [PHASE_W-1:0]  drop;
  logic [PHASE_W-1:0]  din;
  logic [OUT_W-1:0]    phase_out;
  logic                wrap;
  logic [SLOT_W-1:0]   slot;
  logic                sync;
  logic                ready;

  modport master (
    output cen, pinc, keyon, drop,
    input  din, phase_out, wrap, slot, sync, ready
  );

  modport slave (
    input  cen, pinc, keyon, drop,
    output din, phase_out, wrap, slot, sync, ready
  );
endinterface

// File: rtl/opm_pg_acc.sv
// Per-slot phase accumulator with an external delay line; a first lap after
// reset writes zero into every delay-line entry before normal accumulation.
module opm_pg_acc #(
  parameter int PHASE_W = 20,
  parameter int PINC_W  = 17,
  parameter int OUT_W   = 10,
  parameter int SLOTS   = 32
) (
  input  logic       clk,
  input  logic       rst,
  opm_pg_acc_if.slave bus
);
  localparam int SLOT_W = $clog2(SLOTS);

  typedef enum logic {INIT, RUN} state_t;

  state_t              state_q;
  logic [SLOT_W-1:0]   init_cnt_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [OUT_W-1:0]    phase_out_q;
  logic                wrap_q;

  logic [PHASE_W:0]    sum_d;
  logic [PHASE_W-1:0]  next_d;

  always_comb begin
    sum_d  = {1'b0, bus.drop} + {{(PHASE_W + 1 - PINC_W){1'b0}}, bus.pinc};
    next_d = bus.keyon ? '0 : sum_d[PHASE_W-1:0];
  end

  // Zero-latency path so one delay-line lap equals one slot period.
  assign bus.din       = (state_q == RUN) ? next_d : '0;
  assign bus.phase_out = phase_out_q;
  assign bus.wrap      = wrap_q;
  assign bus.slot      = slot_q;
  assign bus.sync      = (slot_q == '0);
  assign bus.ready     = (state_q == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      slot_q      <= '0;
      phase_out_q <= '0;
      wrap_q      <= 1'b0;
    end else if (bus.cen) begin
      slot_q <= slot_q + 1'b1;
      case (state_q)
        INIT: begin
          init_cnt_q  <= init_cnt_q + 1'b1;
          phase_out_q <= '0;
          wrap_q      <= 1'b0;
          if (init_cnt_q == '1) state_q <= RUN;
        end
        RUN: begin
          phase_out_q <= next_d[PHASE_W-1 -: OUT_W];
          wrap_q      <= sum_d[PHASE_W] & ~bus.keyon;
        end
        default: state_q <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_opm_pg_acc.sv
// Scoreboard bench for opm_pg_acc: stimulus pushes expected slot outputs,
// a negedge monitor pops and compares them.
module tb_opm_pg_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  opm_pg_acc_if #(.PHASE_W(20), .PINC_W(17), .OUT_W(10), .SLOTS(32)) bus ();

  opm_pg_acc #(.PHASE_W(20), .PINC_W(17), .OUT_W(10), .SLOTS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [19:0] din;
    logic [9:0]  po;
    logic        wrap;
    logic [4:0]  slot;
    logic        ready;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [4:0]  m_slot;
  logic [9:0]  m_po;
  logic        m_wrap;
  logic        m_ready;
  int          m_cnt;
  logic [19:0] mem [32];
  logic [19:0] din_cap;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("din",       32'(bus.din),       32'(e.din));
      chk("phase_out", 32'(bus.phase_out), 32'(e.po));
      chk("wrap",      32'(bus.wrap),      32'(e.wrap));
      chk("slot",      32'(bus.slot),      32'(e.slot));
      chk("sync",      32'(bus.sync),      32'(e.slot == 5'd0));
      chk("ready",     32'(bus.ready),     32'(e.ready));
    end
  end

  function automatic void model_reset();
    m_slot = '0; m_po = '0; m_wrap = 1'b0; m_ready = 1'b0; m_cnt = 0;
  endfunction

  // Inputs applied 1 time unit after a rising edge; expectation checked at the negedge.
  task automatic step(input logic c, input logic [16:0] p, input logic k,
                      input logic [19:0] d, input logic [19:0] exp_din,
                      input logic exp_wrap);
    exp_t e;
    bus.cen = c; bus.pinc = p; bus.keyon = k; bus.drop = d;
    e.din = exp_din; e.po = m_po; e.wrap = m_wrap; e.slot = m_slot; e.ready = m_ready;
    q.push_back(e);
    #4 din_cap = bus.din;
    @(posedge clk);
    #1;
    if (c) begin
      mem[m_slot] = din_cap;
      if (m_ready) begin
        m_po   = exp_din[19:10];
        m_wrap = exp_wrap;
      end else begin
        m_cnt++;
        if (m_cnt == 32) m_ready = 1'b1;
      end
      m_slot = m_slot + 5'd1;
    end
  endtask

  task automatic init_lap();
    for (int i = 0; i < 32; i++)
      step(1'b1, 17'h1FFFF, i[0], 20'hFFFFF, 20'h00000, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.cen = 1'b0; bus.pinc = '0; bus.keyon = 1'b0; bus.drop = '0;
    for (int i = 0; i < 32; i++) mem[i] = 20'hFFFFF;
    model_reset();
    #1;
    chk("rst_slot",  32'(bus.slot),      32'd0);
    chk("rst_ready", 32'(bus.ready),     32'd0);
    chk("rst_sync",  32'(bus.sync),      32'd1);
    chk("rst_po",    32'(bus.phase_out), 32'd0);
    chk("rst_wrap",  32'(bus.wrap),      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // INIT lap: din forced to zero, clearing the delay line
    init_lap();

    // Loopback through the delay line: only slot 3 accumulates
    for (int lap = 0; lap < 3; lap++)
      for (int s = 0; s < 32; s++)
        step(1'b1, (s == 3) ? 17'd1 : 17'd0, 1'b0, mem[s],
             (s == 3) ? 20'(lap + 1) : 20'd0, 1'b0);

    // Overflow, keyon, hold, and a nonzero phase_out / wrap pair
    step(1'b1, 17'h00001, 1'b0, 20'hFFFFF, 20'h00000, 1'b1);
    step(1'b1, 17'h00100, 1'b1, 20'h12345, 20'h00000, 1'b0);
    step(1'b1, 17'h00100, 1'b0, 20'h12345, 20'h12445, 1'b0);
    step(1'b1, 17'h00000, 1'b0, 20'hABCDE, 20'hABCDE, 1'b0);
    step(1'b1, 17'h1FFFF, 1'b0, 20'hFFFFF, 20'h1FFFE, 1'b1);

    // cen low: registers hold, din still combinational
    for (int i = 0; i < 10; i++)
      step(1'b0, 17'h00003, 1'b0, 20'h00005, 20'h00008, 1'b0);

    // keyon together with overflow
    step(1'b1, 17'h1FFFF, 1'b1, 20'hFFFFF, 20'h00000, 1'b0);
    step(1'b1, 17'h00000, 1'b0, 20'hFFC00, 20'hFFC00, 1'b0);
    while (m_slot != 5'd17)
      step(1'b1, 17'h00000, 1'b0, 20'hFFC00, 20'hFFC00, 1'b0);

    // Asynchronous reset mid-RUN at slot 17, checked without a clock edge
    chk("pre_rst_slot", 32'(bus.slot),      32'd17);
    chk("pre_rst_po",   32'(bus.phase_out), 32'h3FF);
    #2 rst = 1'b1;
    #1;
    chk("arst_slot",  32'(bus.slot),      32'd0);
    chk("arst_ready", 32'(bus.ready),     32'd0);
    chk("arst_sync",  32'(bus.sync),      32'd1);
    chk("arst_po",    32'(bus.phase_out), 32'd0);
    chk("arst_din",   32'(bus.din),       32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    init_lap();
    step(1'b1, 17'h00100, 1'b0, 20'h12345, 20'h12445, 1'b0);
    step(1'b1, 17'h00000, 1'b0, 20'h00000, 20'h00000, 1'b0);

    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/opm_pg_acc.md
OPM_PG_ACC -- requirements
Module: opm_pg_acc

Interface
REQ-001 Parameter PHASE_W, default 20: width of the per-slot phase accumulator held in the external delay line.
REQ-002 Parameter PINC_W, default 17: width of the per-slot phase increment; SHALL be <= PHASE_W.
REQ-003 Parameter OUT_W, default 10: width of the phase sample passed to the operator; SHALL be <= PHASE_W.
REQ-004 Parameter SLOTS, default 32: number of time-multiplexed slots, power of two, equal to the delay-line stage count.
REQ-005 clk  input  1  clock; all registers clocked on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 cen  input  1  clock enable; one slot processed per cycle with cen=1.
REQ-008 pinc  input  PINC_W  phase increment for the current slot.
REQ-009 keyon  input  1  key-on event for the current slot; forces that slot's phase to zero.
REQ-010 drop  input  PHASE_W  stored phase of the current slot, read from the delay-line output.
REQ-011 din  output  PHASE_W  new phase of the current slot, written to the delay-line input.
REQ-012 phase_out  output  OUT_W  registered top OUT_W bits of the new phase.
REQ-013 wrap  output  1  registered flag: the current slot's accumulation overflowed.
REQ-014 slot  output  log2(SLOTS)  index of the slot being processed.
REQ-015 sync  output  1  high while slot==0.
REQ-016 ready  output  1  high in RUN state.

Function
REQ-017 FSM states: INIT, RUN; reset enters INIT.
REQ-018 INIT: internal counter init_cnt counts cen cycles; after SLOTS cen cycles, state moves to RUN on that same edge.
REQ-019 INIT: din SHALL be all-zero regardless of drop, pinc, keyon, clearing every delay-line entry in one lap.
REQ-020 INIT: phase_out and wrap SHALL hold 0; keyon ignored.
REQ-021 RUN: sum = drop + zero-extended pinc, computed in PHASE_W+1 bits; next = keyon ? 0 : sum[PHASE_W-1:0].
REQ-022 RUN: din = next, combinational from drop, pinc, keyon, state (zero added latency, so one delay-line lap = one slot period).
REQ-023 RUN, on cen: phase_out <= next[PHASE_W-1 -: OUT_W]; wrap <= sum[PHASE_W] & ~keyon.
REQ-024 keyon together with overflow: din=0, wrap=0.
REQ-025 pinc=0 without keyon: din equals drop (phase held).
REQ-026 slot increments by 1 on every cen in both states, wrapping SLOTS-1 -> 0; sync derived combinationally from slot.
REQ-027 cen=0: all registers (state, init_cnt, slot, phase_out, wrap) hold; din still follows inputs combinationally.
REQ-028 Downstream delay line SHALL be driven with the same clk and cen; no other handshake exists.

Reset
REQ-029 rst=1 SHALL immediately set state=INIT, init_cnt=0, slot=0, phase_out=0, wrap=0, ready=0 (sync=1), independent of clk and cen.
REQ-030 rst asserted mid-RUN SHALL abort operation; after release a full INIT lap of SLOTS cen cycles is repeated before ready=1.

Verification
REQ-031 Release rst, cen=1 each cycle, drop=0xFFFFF -> din=0 for first 32 cycles, ready=1 after the 32nd edge, slot counts 0..31 then 0.
REQ-032 In RUN, 32-entry loopback model, pinc=1 on slot 3 only, 0 elsewhere -> slot 3 phase increases by 1 per lap, other slots stay 0.
REQ-033 In RUN, drop=0xFFFFF, pinc=0x00001, keyon=0 -> din=0x00000, next-cycle wrap=1, phase_out=0x000.
REQ-034 In RUN, drop=0x12345, pinc=0x00100, keyon=1 -> din=0x00000, phase_out=0, wrap=0; keyon=0 -> din=0x12445, phase_out=0x049.
REQ-035 In RUN, cen=0 for 10 cycles -> slot, phase_out, wrap, ready unchanged.
REQ-036 rst pulsed at slot 17 in RUN -> slot=0, ready=0, phase_out=0 without a clock edge; ready returns 32 cen cycles after release.
